ext_io_bridge: RTL
==================

# ext_io_bridge

Parametrised Avalon-MM slave to external asynchronous-handshake I/O bus bridge, the multi-channel successor to the single 16-bit `io_*` bridge exported from the HPS/Qsys system. It converts one Avalon read or write into a held `io_bus_enable` / `io_acknowledge` transaction on one of `2**CS_BITS` chip-selected peripherals. It adds a per-transaction acknowledge timeout with an error response, plus synchronised, maskable, optionally edge-latched interrupt inputs.

## Interface
- `ADDR_W`, 16: external word-address width.
- `DATA_W`, 16: data width; multiple of 8.
- `CS_BITS`, 2: chip-select index bits; `NUM_CS = 2**CS_BITS`.
- `TIMEOUT`, 255: maximum bus-enable cycles without acknowledge. 0 disables the timeout.
- `IRQ_W`, 1: number of interrupt inputs.
- `IRQ_EDGE`, 0: 0 = level interrupts; 1 = rising-edge latched interrupts.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `avs_address` in `CS_BITS+ADDR_W`: bits [MSBs] select the channel; `[ADDR_W-1:0]` is the external address.
- `avs_read`, `avs_write` in 1: Avalon read and write requests.
- `avs_writedata` in `DATA_W`.
- `avs_byteenable` in `DATA_W/8`.
- `avs_readdata` out `DATA_W`.
- `avs_waitrequest` out 1.
- `avs_response` out 2: 00 = OKAY; 10 = SLVERR (timeout).
- `io_address` out `ADDR_W`.
- `io_cs` out `NUM_CS`: one-hot channel select.
- `io_bus_enable` out 1.
- `io_byte_enable` out `DATA_W/8`.
- `io_rw` out 1: 1 = read, 0 = write.
- `io_write_data` out `DATA_W`.
- `io_read_data` in `DATA_W`.
- `io_acknowledge` in 1.
- `io_irq` in `IRQ_W`: asynchronous.
- `irq_mask` in `IRQ_W`: 1 = enabled.
- `irq_clear` in `IRQ_W`: one-cycle pulse; edge mode only.
- `irq` out 1: OR of enabled pending interrupts.
- `timeout_count` out 16: saturating count of timed-out transactions.

## Operation
- FSM states: IDLE, BUS, DONE.
- **IDLE**
  - If `avs_write` or `avs_read` is high, latch address, channel, byte enables, write data and direction, then go to BUS.
  - If both are high, the write wins.
- **BUS**
  - `io_bus_enable`=1, `io_cs` = one-hot of the latched channel, and all `io_*` outputs are held stable.
  - The cycle counter starts at 0 in the first BUS cycle.
  - If `io_acknowledge`=1 is sampled: on a read, capture `io_read_data` into `avs_readdata`; set response 00; go to DONE.
  - Otherwise, if `TIMEOUT`≠0 and counter == `TIMEOUT-1`: set response 10, `avs_readdata` = all ones, increment `timeout_count` (saturating at 0xFFFF), go to DONE.
- **DONE**
  - `avs_waitrequest`=0 for exactly one cycle.
  - `io_bus_enable`=0, `io_cs`=0.
  - Return to IDLE.
- `avs_waitrequest`=1 in every cycle except DONE. Requests arriving in BUS or DONE are held off and sampled again in IDLE.
- `io_acknowledge` outside BUS is ignored.
- **Interrupts**
  - `io_irq` passes through a 2-flop synchroniser per bit.
  - Level mode: pending = synchronised value.
  - Edge mode: pending bit sets on a synchronised 0→1 transition and clears on `irq_clear`. Set wins when both occur in the same cycle.
  - `irq` is registered: `irq` = |(pending & `irq_mask`).
- **Reset values**
  - State IDLE; `avs_waitrequest`=1; `avs_readdata`=0; `avs_response`=00.
  - All `io_*` outputs 0, except `io_rw`=1.
  - Pending, synchronisers, `irq`, counter and `timeout_count` all 0.
- **Reset mid-transaction**: the transaction is abandoned. `io_bus_enable` and `io_cs` are 0 from the first edge at which `reset` is sampled high, and no response is issued.

## Timing
- Minimum transaction (acknowledge in the first BUS cycle):
  - Request sampled at edge 0.
  - `io_bus_enable` high for cycle 1.
  - `avs_waitrequest` low in cycle 2.
  - Total 3 cycles.
- Acknowledge sampled in BUS cycle k (k ≥ 1): `io_bus_enable` is high for exactly k cycles; `avs_waitrequest` is low at cycle k+1.
- Timeout: `io_bus_enable` is high for exactly `TIMEOUT` cycles.
- `io_acknowledge` arriving on the same edge as the final timeout cycle counts as success.
- At least one idle cycle separates back-to-back transactions: `io_bus_enable` is low for ≥ 2 cycles between them (DONE and IDLE).
- IRQ latency from an `io_irq` edge to `irq`: 3 cycles in level mode, 4 in edge mode.

## Test plan
- Write, channel 2, address 0x1234, data 0xBEEF, BE=11, ack after 3 cycles -> `io_cs`=0100, `io_rw`=0, `io_write_data`=0xBEEF, `io_bus_enable` high 3 cycles, response 00 on the single waitrequest-low cycle.
- Read, channel 0, ack in the first BUS cycle with `io_read_data`=0x5A5A -> `avs_readdata`=0x5A5A, response 00, 3-cycle total latency.
- Read with no ack, `TIMEOUT`=8 -> `io_bus_enable` high exactly 8 cycles, response 10, readdata 0xFFFF, `timeout_count`=1; a following acked transaction returns 00.
- `reset` pulsed in the 2nd BUS cycle -> `io_bus_enable`=0 and `io_cs`=0 next cycle, no waitrequest-low cycle, FSM accepts a new request after reset.
- `IRQ_EDGE`=1, mask=1: pulse `io_irq` -> `irq`=1 after 4 cycles and stays high until `irq_clear`. Clear coinciding with a new edge -> `irq` stays 1. Mask=0 -> `irq`=0.
- `avs_read` and `avs_write` high together -> write performed (`io_rw`=0).

Source files
------------

// File: rtl/ext_io_bridge_if.sv
// Avalon-MM slave side and external async-handshake I/O bus side of ext_io_bridge,
// bundled so the bridge and its environment share one connection object.
interface ext_io_bridge_if #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int CS_BITS = 2
);
   localparam int NUM_CS = 2 ** CS_BITS;
   localparam int BE_W   = DATA_W / 8;

   logic [CS_BITS+ADDR_W-1:0] avs_address;
   logic                      avs_read;
   logic                      avs_write;
   logic [DATA_W-1:0]         avs_writedata;
   logic [BE_W-1:0]           avs_byteenable;
   logic [DATA_W-1:0]         avs_readdata;
   logic                      avs_waitrequest;
   logic [1:0]                avs_response;

   logic [ADDR_W-1:0]         io_address;
   logic [NUM_CS-1:0]         io_cs;
   logic                      io_bus_enable;
   logic [BE_W-1:0]           io_byte_enable;
   logic                      io_rw;
   logic [DATA_W-1:0]         io_write_data;
   logic [DATA_W-1:0]         io_read_data;
   logic                      io_acknowledge;

   // The bridge: Avalon slave towards the host, bus master towards the peripherals.
   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      output avs_readdata, avs_waitrequest, avs_response,
      output io_address, io_cs, io_bus_enable, io_byte_enable, io_rw, io_write_data,
      input  io_read_data, io_acknowledge
   );

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      input  avs_readdata, avs_waitrequest, avs_response,
      input  io_address, io_cs, io_bus_enable, io_byte_enable, io_rw, io_write_data,
      output io_read_data, io_acknowledge
   );
endinterface

// File: rtl/ext_io_bridge.sv
// Avalon-MM slave to chip-selected async-handshake I/O bus bridge with acknowledge
// timeout, saturating timeout counter and synchronised maskable interrupts.
module ext_io_bridge #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int CS_BITS  = 2,
   parameter int TIMEOUT  = 255,
   parameter int IRQ_W    = 1,
   parameter int IRQ_EDGE = 0
) (
   input  logic               clk,
   input  logic               reset,
   ext_io_bridge_if.slave     bus,
   input  logic [IRQ_W-1:0]   io_irq,
   input  logic [IRQ_W-1:0]   irq_mask,
   input  logic [IRQ_W-1:0]   irq_clear,
   output logic               irq,
   output logic [15:0]        timeout_count
);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t              state;
   state_t              next_state;
   logic [ADDR_W-1:0]   addr_q;
   logic [CS_BITS-1:0]  chan_q;
   logic [BE_W-1:0]     be_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                rw_q;
   logic [1:0]          resp_q;
   logic [CNT_W-1:0]    cnt;
   logic                start;
   logic                ack_hit;
   logic                timeout_hit;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Acknowledge is tested before the timeout so a late ack on the last cycle still succeeds.
   always_comb begin
      next_state  = state;
      start       = 1'b0;
      ack_hit     = 1'b0;
      timeout_hit = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.avs_read || bus.avs_write) begin
               start      = 1'b1;
               next_state = BUS;
            end
         end
         BUS: begin
            if (bus.io_acknowledge) begin
               ack_hit    = 1'b1;
               next_state = DONE;
            end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
               timeout_hit = 1'b1;
               next_state  = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q        <= '0;
         chan_q        <= '0;
         be_q          <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         rw_q          <= 1'b1;
         resp_q        <= 2'b00;
         cnt           <= '0;
         timeout_count <= '0;
      end else begin
         if (start) begin
            addr_q  <= bus.avs_address[ADDR_W-1:0];
            chan_q  <= bus.avs_address[CS_BITS+ADDR_W-1:ADDR_W];
            be_q    <= bus.avs_byteenable;
            wdata_q <= bus.avs_writedata;
            rw_q    <= ~bus.avs_write;
            cnt     <= '0;
         end else if (state == BUS) begin
            cnt <= cnt + 1'b1;
         end
         if (ack_hit) begin
            if (rw_q) rdata_q <= bus.io_read_data;
            resp_q <= 2'b00;
         end
         if (timeout_hit) begin
            rdata_q <= '1;
            resp_q  <= 2'b10;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
         end
      end
   end

   assign bus.io_bus_enable   = (state == BUS);
   assign bus.avs_waitrequest = (state != DONE);
   assign bus.avs_readdata    = rdata_q;
   assign bus.avs_response    = resp_q;
   assign bus.io_address      = addr_q;
   assign bus.io_byte_enable  = be_q;
   assign bus.io_rw           = rw_q;
   assign bus.io_write_data   = wdata_q;

   always_comb begin
      bus.io_cs = '0;
      if (state == BUS) bus.io_cs[chan_q] = 1'b1;
   end

   logic [IRQ_W-1:0] sync1;
   logic [IRQ_W-1:0] sync2;
   logic [IRQ_W-1:0] pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= io_irq;
         sync2 <= sync1;
      end
   end

   generate
      if (IRQ_EDGE != 0) begin : g_edge
         logic [IRQ_W-1:0] prev;
         logic [IRQ_W-1:0] pend_q;
         // A new rising edge overrides a clear arriving on the same cycle.
         always_ff @(posedge clk) begin
            if (reset) begin
               prev   <= '0;
               pend_q <= '0;
            end else begin
               prev   <= sync2;
               pend_q <= (pend_q & ~irq_clear) | (sync2 & ~prev);
            end
         end
         assign pending = pend_q;
      end else begin : g_level
         logic [IRQ_W-1:0] unused_clear;
         assign unused_clear = irq_clear;
         assign pending      = sync2;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= |(pending & irq_mask);
   end
endmodule
